// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: debounced mode switch steps through five LED patterns,
// each advanced by a prescaled tick.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DEB_LEN  = 500000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       SW,
  output logic [7:0] oLED,
  output logic [2:0] oMODE
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_LEN - 1);

  typedef enum logic [2:0] {
    SHL    = 3'd0,
    SHR    = 3'd1,
    BOUNCE = 3'd2,
    BLINK  = 3'd3,
    COUNT  = 3'd4
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [7:0]    led_q, led_d;
  logic          dir_q, dir_d;      // BOUNCE direction: 0 = left, 1 = right
  logic [PW-1:0] presc_q, presc_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          acc_q, acc_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          adv_q, adv_d;
  logic          tick_c;

  function automatic logic [7:0] init_pattern(input mode_e m);
    case (m)
      SHL:     return 8'h01;
      SHR:     return 8'h80;
      BOUNCE:  return 8'h01;
      BLINK:   return 8'hFF;
      COUNT:   return 8'h00;
      default: return 8'h01;
    endcase
  endfunction

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_q    <= SHL;
      led_q     <= 8'h01;
      dir_q     <= 1'b0;
      presc_q   <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      acc_q     <= 1'b0;
      deb_cnt_q <= '0;
      adv_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      acc_q     <= acc_d;
      deb_cnt_q <= deb_cnt_d;
      adv_q     <= adv_d;
    end
  end

  // Synchroniser and debouncer; adv_d fires only when the accepted level rises.
  always_comb begin
    sync1_d   = SW;
    sync2_d   = sync1_q;
    acc_d     = acc_q;
    deb_cnt_d = '0;
    adv_d     = 1'b0;
    if (sync2_q != acc_q) begin
      if (deb_cnt_q == DEB_MAX) begin
        acc_d = sync2_q;
        adv_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  assign tick_c = (presc_q == PRESC_MAX);

  // Mode FSM and pattern generator; an advance pulse overrides a coincident tick.
  always_comb begin
    mode_d  = mode_q;
    led_d   = led_q;
    dir_d   = dir_q;
    presc_d = tick_c ? '0 : presc_q + PW'(1);
    if (adv_q) begin
      case (mode_q)
        SHL:     mode_d = SHR;
        SHR:     mode_d = BOUNCE;
        BOUNCE:  mode_d = BLINK;
        BLINK:   mode_d = COUNT;
        default: mode_d = SHL;
      endcase
      led_d   = init_pattern(mode_d);
      dir_d   = 1'b0;
      presc_d = '0;
    end else begin
      case (mode_q)
        SHL:    if (tick_c) led_d = {led_q[6:0], led_q[7]};
        SHR:    if (tick_c) led_d = {led_q[0], led_q[7:1]};
        BOUNCE: begin
          if (tick_c) begin
            if (!dir_q) begin
              led_d = {led_q[6:0], 1'b0};
              if (led_q == 8'h40) dir_d = 1'b1;
            end else begin
              led_d = {1'b0, led_q[7:1]};
              if (led_q == 8'h02) dir_d = 1'b0;
            end
          end
        end
        BLINK:  if (tick_c) led_d = ~led_q;
        COUNT:  if (tick_c) led_d = led_q + 8'd1;
        default: begin
          mode_d = SHL;
          led_d  = 8'h01;
          dir_d  = 1'b0;
        end
      endcase
    end
  end

  assign oLED  = led_q;
  assign oMODE = mode_q;

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, iCLK cycles per pattern step (0.5 s at 50 MHz); legal range >= 2.
REQ-002 Parameter DEB_LEN, default 500000, consecutive stable synchronised cycles required to accept a new SW level; legal range >= 2.
REQ-003 iCLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 iRST  input  1  asynchronous, active-high reset.
REQ-005 SW  input  1  asynchronous mode-select switch; each accepted 0->1 transition advances the mode.
REQ-006 oLED  output  8  registered LED pattern.
REQ-007 oMODE  output  3  registered current mode code.

Function
REQ-008 SW SHALL pass through a two-flop synchroniser before any other use.
REQ-009 Debouncer SHALL keep an accepted level; when the synchronised level has differed from it for DEB_LEN consecutive cycles, the accepted level SHALL flip; any return to the accepted level SHALL clear the count to 0.
REQ-010 A 0->1 flip of the accepted level SHALL raise a one-cycle advance pulse; a 1->0 flip SHALL have no effect.
REQ-011 Mode FSM SHALL have states SHL=0, SHR=1, BOUNCE=2, BLINK=3, COUNT=4, advancing SHL->SHR->BOUNCE->BLINK->COUNT->SHL, one step per advance pulse; codes 5-7 unreachable, and SHALL recover to SHL if ever entered.
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where the count equals TICK_DIV-1.
REQ-013 On an advance pulse, the cycle after: oMODE = new mode, oLED = new mode's initial pattern, prescaler = 0, BOUNCE direction = left.
REQ-014 Initial patterns: SHL 8'h01, SHR 8'h80, BOUNCE 8'h01, BLINK 8'hFF, COUNT 8'h00.
REQ-015 On each tick, with no advance pulse: SHL rotates oLED left by 1 (bit7->bit0); SHR rotates right by 1 (bit0->bit7).
REQ-016 BOUNCE on tick: shift in current direction; reaching 8'h80 while moving left SHALL set direction right; reaching 8'h01 while moving right SHALL set direction left; sequence 01,02,..,80,40,..,01,02,... with no repeated end value.
REQ-017 BLINK on tick: oLED = ~oLED (FF,00,FF,...).
REQ-018 COUNT on tick: oLED = oLED + 1 modulo 256 (FF wraps to 00).
REQ-019 Advance pulse and tick in the same cycle: advance SHALL win; no pattern step applied.
REQ-020 Latency: SW edge to oMODE change SHALL be 2 (sync) + DEB_LEN + 1 cycles, +/-1 cycle for input sampling alignment.
REQ-021 SW glitches shorter than DEB_LEN cycles SHALL cause no mode change.

Reset
REQ-022 On iRST=1, without waiting for iCLK: oMODE=0 (SHL), oLED=8'h01, prescaler=0, debounce count=0, accepted level=0, synchroniser flops=0, BOUNCE direction=left.
REQ-023 Reset asserted mid-pattern or mid-debounce SHALL discard all progress; first tick after release SHALL occur TICK_DIV cycles after the first active clock edge.
REQ-024 SW held high through reset release SHALL be treated as a 0->1 transition and advance to SHR after the debounce latency.

Verification (TICK_DIV=4, DEB_LEN=3)
REQ-025 Reset, SW=0, run 40 cycles -> oLED 01,02,04,...,80,01 changing every 4 cycles, oMODE=0 throughout.
REQ-026 SW 0->1 held -> oMODE=1 within 6-7 cycles, oLED=80 same cycle, then 40,20,... every 4 cycles; SW 1->0 -> no mode change.
REQ-027 SW pulses of 1 and 2 cycles -> oMODE unchanged, oLED pattern unaffected.
REQ-028 Advance to BOUNCE, run 64 cycles -> oLED 01,02,...,80,40,...,01,02; no value repeated at ends.
REQ-029 Advance to COUNT, run 1030 cycles -> oLED increments every 4 cycles, FF->00 wrap; one more advance -> oMODE=0, oLED=01.
REQ-030 Align SW accept with prescaler count 3, then assert iRST asynchronously mid-cycle -> oLED=01, oMODE=0 immediately; after release first step at cycle 4.
